// File: rtl/mesh_host_driver_pkg.sv
// rtl/mesh_host_driver_pkg.sv - shared mesh types, sizes and preload address packing
package mesh_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int NUM_PE = ROWS * COLS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } state_t;

    // Same {row, col} packing the mesh decoder uses to steer a preload beat.
    function automatic int unsigned pack_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned col_w);
        return (row << col_w) | col;
    endfunction

endpackage

// File: rtl/mesh_host_driver_if.sv
// rtl/mesh_host_driver_if.sv - host command, mesh preload/start and result signals
interface mesh_host_driver_if #(
    parameter int DW    = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int ROW_W = 2,
    parameter int COL_W = 2,
    parameter int ACC_W = 16
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [ROWS*COLS*DW-1:0]     cmd_weight_flat;
    logic [COLS*DW-1:0]          cmd_x_flat;
    logic                        preload_valid;
    logic [ROW_W+COL_W-1:0]      preload_addr;
    logic [DW-1:0]               preload_data;
    logic                        start;
    logic [COLS*DW-1:0]          x_vector_flat;
    logic [ROWS*ACC_W-1:0]       result_flat;
    logic                        res_valid;
    logic                        res_ready;
    logic [ROWS*ACC_W-1:0]       res_data;

    modport slave (
        input  cmd_valid, cmd_weight_flat, cmd_x_flat, result_flat, res_ready,
        output cmd_ready, preload_valid, preload_addr, preload_data, start,
               x_vector_flat, res_valid, res_data
    );

    modport master (
        output cmd_valid, cmd_weight_flat, cmd_x_flat, result_flat, res_ready,
        input  cmd_ready, preload_valid, preload_addr, preload_data, start,
               x_vector_flat, res_valid, res_data
    );
endinterface

// File: rtl/mesh_host_driver_beat_counter.sv
// rtl/mesh_host_driver_beat_counter.sv - saturating terminal-count counter
module mesh_beat_counter #(
    parameter int W    = 4,
    parameter int LAST = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);
    assign last = (count == W'(LAST));

    // Holds at LAST so the index can never wrap back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !last) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mesh_host_driver.sv
// rtl/mesh_host_driver.sv - job sequencer: preload weights, start mesh, capture result
module mesh_host_driver
    import mesh_pkg::*;
#(
    parameter int DW          = 8,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int ROW_W       = 2,
    parameter int COL_W       = 2,
    parameter int ACC_W       = 16,
    parameter int COMPUTE_LAT = 12,
    parameter int LAT_W       = 4
) (
    input logic               clk,
    input logic               rst,
    mesh_host_driver_if.slave bus
);
    localparam int AW = ROW_W + COL_W;

    state_t                  state, state_nxt;
    logic [ROWS*COLS*DW-1:0] weight_q;
    logic [AW-1:0]           beat;
    logic [AW-1:0]           beat_nxt;
    logic                    beat_last;
    logic [LAT_W-1:0]        unused_wait_count;
    logic                    wait_last;
    logic                    accept;
    logic                    capture;
    logic                    pv_d;
    logic [AW-1:0]           pa_d;
    logic [DW-1:0]           pd_d;

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] i);
        return AW'(pack_addr(i / COLS, i % COLS, COL_W));
    endfunction

    assign accept        = (state == IDLE) && bus.cmd_valid;
    assign capture       = (state == WAIT) && wait_last;
    assign beat_nxt      = beat + 1'b1;
    assign bus.cmd_ready = (state == IDLE);

    mesh_beat_counter #(.W(AW), .LAST(ROWS*COLS-1)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (state == LOAD),
        .count (beat),
        .last  (beat_last)
    );

    mesh_beat_counter #(.W(LAT_W), .LAST(COMPUTE_LAT-1)) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state == START),
        .en    (state == WAIT),
        .count (unused_wait_count),
        .last  (wait_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Beat 0 is taken straight from the command so it lands in the cycle after acceptance.
    always_comb begin
        state_nxt = state;
        pv_d      = 1'b0;
        pa_d      = '0;
        pd_d      = '0;
        case (state)
            IDLE: if (accept) begin
                state_nxt = LOAD;
                pv_d      = 1'b1;
                pa_d      = beat_addr('0);
                pd_d      = bus.cmd_weight_flat[0 +: DW];
            end
            LOAD: if (beat_last) begin
                state_nxt = START;
            end else begin
                pv_d = 1'b1;
                pa_d = beat_addr(beat_nxt);
                pd_d = weight_q[beat_nxt*DW +: DW];
            end
            START:   state_nxt = WAIT;
            WAIT:    if (wait_last) state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.preload_valid <= 1'b0;
            bus.preload_addr  <= '0;
            bus.preload_data  <= '0;
            bus.start         <= 1'b0;
            bus.res_valid     <= 1'b0;
            bus.res_data      <= '0;
            bus.x_vector_flat <= '0;
            weight_q          <= '0;
        end else begin
            bus.preload_valid <= pv_d;
            bus.preload_addr  <= pa_d;
            bus.preload_data  <= pd_d;
            bus.start         <= (state_nxt == START);
            bus.res_valid     <= (state_nxt == DONE);
            if (accept) begin
                weight_q          <= bus.cmd_weight_flat;
                bus.x_vector_flat <= bus.cmd_x_flat;
            end
            if (capture) bus.res_data <= bus.result_flat;
        end
    end
endmodule

// File: tb/tb_mesh_host_driver.sv
// tb/tb_mesh_host_driver.sv - directed self-checking bench for mesh_host_driver
module tb_mesh_host_driver;
    import mesh_pkg::*;

    localparam int DW = 8, R = 4, C = 4, RW = 2, CW = 2, AC = 16, LAT = 12, LW = 4;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mesh_host_driver_if #(.DW(DW), .ROWS(R), .COLS(C), .ROW_W(RW), .COL_W(CW), .ACC_W(AC)) bus ();

    mesh_host_driver #(
        .DW(DW), .ROWS(R), .COLS(C), .ROW_W(RW), .COL_W(CW), .ACC_W(AC),
        .COMPUTE_LAT(LAT), .LAT_W(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one job, checks every beat, the start pulse and the capture timing; leaves DUT in DONE.
    task automatic run_job(input logic [127:0] w, input logic [31:0] x, input logic [63:0] r);
        bus.cmd_weight_flat = w;
        bus.cmd_x_flat      = x;
        bus.cmd_valid       = 1'b1;
        bus.result_flat     = ~r;
        check("ready_before_job", 128'(bus.cmd_ready), 128'd1);
        tick();
        bus.cmd_valid       = 1'b0;
        bus.cmd_weight_flat = '0;
        check("x_vector", 128'(bus.x_vector_flat), 128'(x));
        check("ready_in_load", 128'(bus.cmd_ready), 128'd0);
        for (int k = 0; k < NUM_PE; k++) begin
            check($sformatf("beat%0d_valid", k), 128'(bus.preload_valid), 128'd1);
            check($sformatf("beat%0d_addr", k), 128'(bus.preload_addr), 128'(k));
            check($sformatf("beat%0d_data", k), 128'(bus.preload_data), 128'(w[k*DW +: DW]));
            check($sformatf("beat%0d_nostart", k), 128'(bus.start), 128'd0);
            tick();
        end
        check("start_pulse", 128'(bus.start), 128'd1);
        check("preload_off_valid", 128'(bus.preload_valid), 128'd0);
        check("preload_off_addr", 128'(bus.preload_addr), 128'd0);
        check("preload_off_data", 128'(bus.preload_data), 128'd0);
        for (int j = 0; j < LAT; j++) begin
            tick();
            check($sformatf("wait%0d_start", j), 128'(bus.start), 128'd0);
            check($sformatf("wait%0d_res_valid", j), 128'(bus.res_valid), 128'd0);
        end
        bus.result_flat = r;
        tick();
        bus.result_flat = ~r;
        check("res_valid_rise", 128'(bus.res_valid), 128'd1);
        check("res_data", 128'(bus.res_data), 128'(r));
        check("ready_in_done", 128'(bus.cmd_ready), 128'd0);
    endtask

    task automatic release_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("release_ready", 128'(bus.cmd_ready), 128'd1);
        check("release_valid", 128'(bus.res_valid), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w1, w2, w4;
        logic [31:0]  x1, x2, x4;
        logic [63:0]  r1, r2, r4, ra, rb;
        logic         seen_start, seen_rv, seen_pv;
        int           nres;
        int           t_res [2];
        logic [63:0]  d_res [2];

        for (int i = 0; i < NUM_PE; i++) begin
            w1[i*DW +: DW] = 8'(i + 1);
            w2[i*DW +: DW] = (i % 2 == 1) ? 8'hFF : 8'h80;
            w4[i*DW +: DW] = 8'(8'hA0 + i);
        end
        x1 = 32'h04030201;  r1 = 64'h1234_0056_FF00_0ABC;
        x2 = 32'hFF80_7F01; r2 = 64'h8000_FFFF_FF80_0001;
        x4 = 32'h1122_3344; r4 = 64'h0102_0304_0506_0708;
        ra = 64'hAAAA_0001_0002_0003;
        rb = 64'h5555_FFFE_FFFD_FFFC;

        bus.cmd_valid = 1'b0; bus.cmd_weight_flat = '0; bus.cmd_x_flat = '0;
        bus.result_flat = '0; bus.res_ready = 1'b0;
        rst = 1'b1;
        #12;
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("rst_pvalid", 128'(bus.preload_valid), 128'd0);
        check("rst_paddr", 128'(bus.preload_addr), 128'd0);
        check("rst_pdata", 128'(bus.preload_data), 128'd0);
        check("rst_start", 128'(bus.start), 128'd0);
        check("rst_res_valid", 128'(bus.res_valid), 128'd0);
        check("rst_res_data", 128'(bus.res_data), 128'd0);
        check("rst_x", 128'(bus.x_vector_flat), 128'd0);
        @(negedge clk) rst = 1'b0;
        tick();
        check("idle_ready", 128'(bus.cmd_ready), 128'd1);
        check("idle_pvalid", 128'(bus.preload_valid), 128'd0);

        run_job(w1, x1, r1);
        release_result();

        run_job(w2, x2, r2);
        bus.cmd_valid = 1'b1;
        bus.cmd_x_flat = 32'hDEAD_BEEF;
        bus.cmd_weight_flat = '1;
        for (int s = 0; s < 20; s++) begin
            tick();
            check($sformatf("stall%0d_valid", s), 128'(bus.res_valid), 128'd1);
            check($sformatf("stall%0d_data", s), 128'(bus.res_data), 128'(r2));
            check($sformatf("stall%0d_ready", s), 128'(bus.cmd_ready), 128'd0);
            check($sformatf("stall%0d_pvalid", s), 128'(bus.preload_valid), 128'd0);
        end
        bus.cmd_valid = 1'b0;
        release_result();
        check("x_kept_after_done", 128'(bus.x_vector_flat), 128'(x2));

        bus.cmd_weight_flat = w1; bus.cmd_x_flat = x1; bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (7) tick();
        check("abort_at_beat7", 128'(bus.preload_addr), 128'd7);
        #2 rst = 1'b1;
        #1;
        check("abort_pvalid", 128'(bus.preload_valid), 128'd0);
        check("abort_paddr", 128'(bus.preload_addr), 128'd0);
        check("abort_pdata", 128'(bus.preload_data), 128'd0);
        check("abort_x", 128'(bus.x_vector_flat), 128'd0);
        check("abort_ready", 128'(bus.cmd_ready), 128'd1);
        @(negedge clk) rst = 1'b0;
        seen_start = 1'b0; seen_rv = 1'b0; seen_pv = 1'b0;
        repeat (40) begin
            tick();
            seen_start |= bus.start;
            seen_rv    |= bus.res_valid;
            seen_pv    |= bus.preload_valid;
        end
        check("abort_no_start", 128'(seen_start), 128'd0);
        check("abort_no_res_valid", 128'(seen_rv), 128'd0);
        check("abort_no_beats", 128'(seen_pv), 128'd0);

        run_job(w4, x4, r4);
        release_result();

        bus.res_ready = 1'b1;
        bus.cmd_weight_flat = w1; bus.cmd_x_flat = x1; bus.result_flat = ra;
        bus.cmd_valid = 1'b1;
        nres = 0;
        for (int c = 0; c < 100 && nres < 2; c++) begin
            tick();
            if (bus.res_valid) begin
                t_res[nres] = c;
                d_res[nres] = bus.res_data;
                nres++;
                bus.result_flat = rb;
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        check("b2b_count", 128'(nres), 128'd2);
        check("b2b_first_latency", 128'(t_res[0]), 128'd29);
        check("b2b_period", 128'(t_res[1] - t_res[0]), 128'd31);
        check("b2b_data0", 128'(d_res[0]), 128'(ra));
        check("b2b_data1", 128'(d_res[1]), 128'(rb));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mesh_host_driver.md
# mesh_host_driver

Host-side initiator for the systolic mesh's preload/start/result interface. Accepts one job per handshake: a full ROWS×COLS weight matrix plus an input vector. Streams the weights into the mesh one per cycle over the preload port, pulses `start`, and waits a fixed compute latency. It then captures `result_flat` and presents it on a valid/ready result port. Sits between the host/DMA and the mesh top, driving every input of the mesh top except `clk`.

## Interface
Parameters:
- `DW`, 8, weight/activation width (signed)
- `ROWS`, 4, mesh rows
- `COLS`, 4, mesh columns
- `ROW_W`, 2, row index width
- `COL_W`, 2, column index width
- `ACC_W`, 16, per-row result width
- `COMPUTE_LAT`, 12, cycles from the `start` pulse to a stable `result_flat`
- `LAT_W`, 4, width of the wait counter; must satisfy COMPUTE_LAT < 2^LAT_W

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  job offered
- `cmd_ready`  out  1  driver can accept a job
- `cmd_weight_flat`  in  ROWS*COLS*DW  weights, element i = r*COLS+c at bits [i*DW +: DW]
- `cmd_x_flat`  in  COLS*DW  input vector
- `preload_valid`  out  1  preload beat valid
- `preload_addr`  out  ROW_W+COL_W  {row, col} of the beat
- `preload_data`  out  DW  signed weight of the beat
- `start`  out  1  one-cycle compute trigger
- `x_vector_flat`  out  COLS*DW  registered input vector to the mesh
- `result_flat`  in  ROWS*ACC_W  mesh result
- `res_valid`  out  1  captured result available
- `res_ready`  in  1  consumer accepts the result
- `res_data`  out  ROWS*ACC_W  captured result

## Operation
- FSM states: IDLE → LOAD → START → WAIT → DONE → IDLE.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid && cmd_ready`, register `cmd_weight_flat` and `cmd_x_flat`, clear the beat index, and go to LOAD.
- **LOAD**
  - Emits ROWS*COLS consecutive beats with no gaps.
  - Beat index i runs 0 … ROWS*COLS-1.
  - `preload_valid` = 1, `preload_addr` = i, `preload_data` = weight[i*DW +: DW].
  - After beat ROWS*COLS-1, go to START.
- **START**: `start` = 1 for exactly one cycle; clear the wait counter; go to WAIT.
- **WAIT**
  - Count COMPUTE_LAT cycles.
  - On the last WAIT cycle, register `result_flat` into `res_data` and go to DONE.
- **DONE**
  - `res_valid` = 1, with `res_data` held stable.
  - On `res_ready`, go to IDLE.
- `cmd_ready` is 0 in every state except IDLE. Commands are never queued.
- `x_vector_flat` drives the registered vector continuously from acceptance until the next acceptance. It is not cleared on DONE.
- `preload_valid`, `preload_addr` and `preload_data` are registered outputs. `preload_addr` and `preload_data` are 0 whenever `preload_valid` = 0.
- Arithmetic: no arithmetic on data; weights and results pass through bit-exact with sign preserved. The beat index is ROW_W+COL_W bits wide; it ends at ROWS*COLS-1 and is never allowed to wrap.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE
  - `cmd_ready` = 1
  - `preload_valid`, `preload_addr`, `preload_data`, `start`, `res_valid` = 0
  - `res_data` = 0, `x_vector_flat` = 0
- With command acceptance at edge T:
  - preload beats occupy cycles T+1 … T+ROWS*COLS
  - `start` is high in cycle T+ROWS*COLS+1
  - `res_valid` rises at T+ROWS*COLS+2+COMPUTE_LAT; with defaults this is T+30
- Minimum job period with `res_ready` tied high: ROWS*COLS+COMPUTE_LAT+3 cycles.
- A `res_ready` asserted before `res_valid` has no effect.
- `res_valid` and `res_data` are held indefinitely under backpressure.
- `cmd_valid` outside IDLE is ignored. The command must be re-presented once `cmd_ready` = 1.
- If `rst` is asserted mid-job, the job is aborted: no further beats, no `start`, no `res_valid`. Outputs go to their reset values immediately.
- The mesh is assumed to consume one preload beat per cycle without backpressure. There is no `preload_ready`.

## Structure
- Shared package `mesh_pkg`:
  - state enum (IDLE, LOAD, START, WAIT, DONE)
  - `NUM_PE` = ROWS*COLS
  - the addr-packing function {row, col}, shared with the mesh decoder
- One sub-module, `mesh_beat_counter`: a terminal-count counter with `clear`, `en` and `last` signals. It is instantiated twice, once for LOAD beats and once for WAIT cycles.

## Test plan
- Reset, then idle: `cmd_ready` = 1 and all other outputs 0.
- Single job, defaults: weights i+1 (i = 0…15), x = {4, 3, 2, 1}, accept at T.
  - Beats at T+1…T+16 with addr 0…15 and data 1…16.
  - `start` pulse at T+17.
  - `res_valid` at T+30 with `res_data` equal to the `result_flat` value driven at T+29.
- Negative weights (-128, -1): `preload_data` keeps bit-exact sign; `res_data` passes a negative result through unchanged.
- Backpressure: hold `res_ready` = 0 for 20 cycles after `res_valid`.
  - `res_valid` and `res_data` stay stable; `cmd_ready` stays 0.
  - A `cmd_valid` offered during the stall is not accepted.
  - When `res_ready` = 1, the state returns to IDLE the next cycle.
- Reset mid-LOAD at beat 7: outputs clear asynchronously. After release there is no `start` and no `res_valid`, and a new job runs cleanly.
- Back-to-back with `res_ready` tied high: two jobs complete 31 cycles apart with correct, distinct `res_data`.
